// File: rtl/one_cycle_pulse_generator.sv
// Pulse-train generator: emits num_pulses high phases of high_len cycles separated
// by gap_len low cycles, then a one-cycle done strobe. Outputs are registered.
module one_cycle_pulse_generator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] gap_len,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;      // remaining cycles in phase, minus one
  logic [CNT_W-1:0] left, left_n;    // pulses still to finish, incl. current
  logic [CNT_W-1:0] hi_q, gap_q;     // captured effective lengths (never 0)
  logic [CNT_W-1:0] hi_eff, gap_eff;
  logic             accept;

  assign hi_eff  = (high_len == '0) ? ONE : high_len;
  assign gap_eff = (gap_len  == '0) ? ONE : gap_len;
  assign accept  = (state == IDLE || state == DONE) && start && !abort;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    left_n  = left;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
          if (num_pulses == '0) begin
            state_n = DONE;
          end else begin
            state_n = HIGH;
            cnt_n   = hi_eff - ONE;
            left_n  = num_pulses;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          if (left == ONE) begin
            state_n = DONE;
            left_n  = '0;
          end else begin
            state_n = GAP;
            cnt_n   = gap_q - ONE;
            left_n  = left - ONE;
          end
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      GAP: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = HIGH;
          cnt_n   = hi_q - ONE;
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      left  <= '0;
      hi_q  <= '0;
      gap_q <= '0;
      pulse <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      left  <= left_n;
      if (accept) begin
        hi_q  <= hi_eff;
        gap_q <= gap_eff;
      end
      // outputs registered from next state so they track state exactly
      pulse <= (state_n == HIGH);
      busy  <= (state_n == HIGH) || (state_n == GAP);
      done  <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_one_cycle_pulse_generator.sv
// Directed bench for one_cycle_pulse_generator; traces outputs per cycle and
// compares against hand-computed waveforms, plus a 0-1-0 pulse detector model.
module tb_one_cycle_pulse_generator;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] num_pulses, high_len, gap_len;
  logic       pulse, busy, done;

  int errors = 0;
  int checks = 0;

  // per-trace results: bit i = cycle i+1
  logic [31:0] pv, bv, dv;
  int npulse, ndone, first_done, ndet;

  always #5 clk = ~clk;

  one_cycle_pulse_generator #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_pulses(num_pulses), .high_len(high_len), .gap_len(gap_len),
    .pulse(pulse), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Caller sets inputs for cycle 0. Start/abort/rst are then re-driven each cycle
  // (asserted only in cycles s2, s3 / a_at / r_at respectively).
  task automatic trace(input int n, input int s2, input int s3, input int a_at,
                       input int r_at, input bit scramble);
    logic p1, p2;
    p1 = 1'b0; p2 = 1'b0;
    pv = '0; bv = '0; dv = '0;
    npulse = 0; ndone = 0; first_done = -1; ndet = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i < 32) begin
        pv[i] = pulse; bv[i] = busy; dv[i] = done;
      end
      if (pulse) npulse++;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = i + 1;
      end
      if (!p2 && p1 && !pulse) ndet++;
      p2 = p1; p1 = pulse;
      start = (i + 1 == s2) || (i + 1 == s3);
      abort = (i + 1 == a_at);
      rst   = (i + 1 == r_at);
      if (scramble && i == 0) begin
        num_pulses = 8'd9; high_len = 8'd9; gap_len = 8'd9;
      end
    end
  endtask

  task automatic go(input logic [7:0] n, input logic [7:0] h, input logic [7:0] g);
    num_pulses = n; high_len = h; gap_len = g; start = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    num_pulses = 8'd3; high_len = 8'd1; gap_len = 8'd1;
    @(posedge clk); #1;
    chk("rst_pulse", {31'b0, pulse}, 0);
    chk("rst_busy",  {31'b0, busy},  0);
    chk("rst_done",  {31'b0, done},  0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {31'b0, busy}, 0);

    // three single-cycle pulses, inputs changed after capture
    go(3, 1, 2); trace(9, 0, 0, 0, 0, 1'b1);
    chk("t1_pulse", pv & 32'h1FF, 32'h049);
    chk("t1_busy",  bv & 32'h1FF, 32'h07F);
    chk("t1_done",  dv & 32'h1FF, 32'h080);

    // zero lengths behave as one
    go(2, 0, 0); trace(5, 0, 0, 0, 0, 1'b0);
    chk("t2_pulse", pv & 32'h1F, 32'h05);
    chk("t2_busy",  bv & 32'h1F, 32'h07);
    chk("t2_done",  dv & 32'h1F, 32'h08);

    // zero pulses: immediate done
    go(0, 4, 4); trace(3, 0, 0, 0, 0, 1'b0);
    chk("t3_pulse", pv & 32'h7, 32'h0);
    chk("t3_busy",  bv & 32'h7, 32'h0);
    chk("t3_done",  dv & 32'h7, 32'h1);

    // ignored start at cycle 3, back-to-back start in done cycle 6
    go(2, 2, 1); trace(13, 3, 6, 0, 0, 1'b0);
    chk("t4_pulse", pv & 32'h1FFF, 32'h6DB);
    chk("t4_busy",  bv & 32'h1FFF, 32'h7DF);
    chk("t4_done",  dv & 32'h1FFF, 32'h820);

    // abort in HIGH at cycle 2
    go(4, 3, 1); trace(8, 0, 0, 2, 0, 1'b0);
    chk("t5_pulse", pv & 32'hFF, 32'h03);
    chk("t5_busy",  bv & 32'hFF, 32'h03);
    chk("t5_ndone", ndone, 0);

    // abort with start in IDLE blocks the start
    go(1, 1, 1); abort = 1'b1; trace(3, 0, 0, 0, 0, 1'b0);
    chk("t6_pulse", pv & 32'h7, 32'h0);
    chk("t6_done",  dv & 32'h7, 32'h0);

    // abort with start during DONE returns to IDLE
    go(0, 1, 1); trace(4, 1, 0, 1, 0, 1'b0);
    chk("t7_pulse", pv & 32'hF, 32'h0);
    chk("t7_done",  dv & 32'hF, 32'h1);

    // reset mid-GAP at cycle 3
    go(2, 1, 3); trace(6, 0, 0, 0, 3, 1'b0);
    chk("t8_pulse", pv & 32'h3F, 32'h01);
    chk("t8_busy",  bv & 32'h3F, 32'h07);
    chk("t8_done",  dv & 32'h3F, 32'h00);

    // maximum high length: 255 cycles, no wrap
    go(1, 255, 1); trace(258, 0, 0, 0, 0, 1'b0);
    chk("t9_npulse", npulse, 255);
    chk("t9_done_at", first_done, 256);

    // maximum gap length
    go(2, 1, 255); trace(260, 0, 0, 0, 0, 1'b0);
    chk("t10_npulse", npulse, 2);
    chk("t10_done_at", first_done, 258);

    // maximum pulse count
    go(255, 1, 1); trace(512, 0, 0, 0, 0, 1'b0);
    chk("t11_npulse", npulse, 255);
    chk("t11_done_at", first_done, 510);

    // detector loopback
    go(5, 1, 1); trace(12, 0, 0, 0, 0, 1'b0);
    chk("t12_det_h1", ndet, 5);
    chk("t12_ndone", ndone, 1);
    go(5, 2, 1); trace(16, 0, 0, 0, 0, 1'b0);
    chk("t13_det_h2", ndet, 0);
    chk("t13_npulse", npulse, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
